// File: rtl/dll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dll_rst_seq
//  Purpose  : Reset sequencer and lock supervisor for the clock-phase-adjust
//             DLL. Pulses the DLL reset, waits for LOCKED with a timeout,
//             qualifies lock over a settle interval, and then raises ready.
//             Lock loss or timeout re-runs the reset. After MAX_RETRY failed
//             attempts the block latches fail.
//  Ports    : CLKIN       - free-running reference clock (rising edge)
//             rst         - asynchronous active-high reset
//             locked      - DLL LOCKED output, treated as asynchronous
//             force_reset - synchronous restart request; clears all status
//             dll_rst     - registered reset to the DLL
//             ready       - high only while lock is qualified (RUN)
//             fail        - high only after the retry budget is exhausted
//             retry_cnt   - failed attempts since rst/force_reset (saturates)
//             lock_lost   - sticky flag: lock dropped while in RUN
//  Revision : 1.0 - initial release
// ============================================================================
module dll_rst_seq #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 7,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CLKIN,
    input  logic       rst,
    input  logic       locked,
    input  logic       force_reset,
    output logic       dll_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic       lock_lost
);

    // Terminal counter values; each phase exits on the last count, so the
    // shared counter never wraps.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       MAX_R        = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PULSE     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dll_rst_q;
    logic             ready_q;
    logic             fail_q;
    logic [2:0]       retry_q;
    logic             lock_lost_q;

    logic             lock_meta_q;
    logic             locked_s_q;

    logic             retry_evt_d;
    logic [2:0]       retry_nxt_d;
    logic             retry_exhaust_d;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous LOCKED input.
    // ------------------------------------------------------------------
    always_ff @(posedge CLKIN or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Retry event: timeout while waiting, or loss of synchronized lock
    // during settle or run.
    // ------------------------------------------------------------------
    always_comb begin
        retry_evt_d = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: retry_evt_d = !locked_s_q && (cnt_q == TIMEOUT_LAST);
            ST_SETTLE:    retry_evt_d = !locked_s_q;
            ST_RUN:       retry_evt_d = !locked_s_q;
            default:      retry_evt_d = 1'b0;
        endcase
    end

    assign retry_nxt_d     = retry_q + 3'd1;
    assign retry_exhaust_d = (retry_nxt_d == MAX_R);

    // ------------------------------------------------------------------
    // Sequencer state machine with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge CLKIN or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PULSE;
            cnt_q       <= '0;
            dll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= 3'd0;
            lock_lost_q <= 1'b0;
        end else if (force_reset) begin
            // Restart wins over any simultaneous retry, timeout or RUN entry;
            // while held, cnt stays 0 so the pulse is timed from release.
            state_q     <= ST_PULSE;
            cnt_q       <= '0;
            dll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= 3'd0;
            lock_lost_q <= 1'b0;
        end else if (retry_evt_d) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (state_q == ST_RUN) begin
                lock_lost_q <= 1'b1;
            end
            if (retry_exhaust_d) begin
                retry_q   <= MAX_R;
                state_q   <= ST_FAIL;
                fail_q    <= 1'b1;
                dll_rst_q <= 1'b0;
            end else begin
                retry_q   <= retry_nxt_d;
                state_q   <= ST_PULSE;
                dll_rst_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_PULSE: begin
                    dll_rst_q <= 1'b1;
                    if (cnt_q == RST_LAST) begin
                        // dll_rst drops on the same edge that leaves PULSE.
                        state_q   <= ST_WAIT_LOCK;
                        cnt_q     <= '0;
                        dll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    dll_rst_q <= 1'b0;
                    if (locked_s_q) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Only reached with locked_s high; a low would have
                    // raised a retry event above.
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                ST_FAIL: begin
                    dll_rst_q <= 1'b0;
                    fail_q    <= 1'b1;
                    ready_q   <= 1'b0;
                end
                default: begin
                    // Illegal encoding: restart the reset pulse.
                    state_q   <= ST_PULSE;
                    cnt_q     <= '0;
                    dll_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    fail_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dll_rst   = dll_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lock_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_dll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dll_rst_seq
//  Purpose  : Directed self-checking bench for dll_rst_seq. Expected output
//             vectors {dll_rst, ready, fail, retry_cnt, lock_lost} are queued
//             as each step is driven and popped after the following edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dll_rst_seq;

    logic       CLKIN;
    logic       rst;
    logic       locked;
    logic       force_reset;
    logic       dll_rst;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;
    logic       lock_lost;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] vec;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    dll_rst_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .SETTLE_CYCLES(8),
        .MAX_RETRY    (3),
        .CNT_W        (16)
    ) dut (
        .CLKIN      (CLKIN),
        .rst        (rst),
        .locked     (locked),
        .force_reset(force_reset),
        .dll_rst    (dll_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lock_lost  (lock_lost)
    );

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    task automatic push_exp(input logic d, input logic r, input logic f,
                            input logic [2:0] rc, input logic ll, input string tag);
        exp_t e;
        e.vec = {d, r, f, rc, ll};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [6:0] obs;
        obs = {dll_rst, ready, fail, retry_cnt, lock_lost};
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%b expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.vec) else begin
                n_fail++;
                $error("FAIL %s t=%0t observed{dll_rst,ready,fail,retry,lost}=%b expected=%b",
                       e.tag, $time, obs, e.vec);
            end
        end
    endtask

    // Check outputs now, without waiting for a clock edge.
    task automatic check_now(input logic d, input logic r, input logic f,
                             input logic [2:0] rc, input logic ll, input string tag);
        push_exp(d, r, f, rc, ll, tag);
        pop_check();
    endtask

    // n clock steps, each expecting the same output vector after the edge.
    task automatic run(input int n, input logic d, input logic r, input logic f,
                       input logic [2:0] rc, input logic ll, input string tag);
        for (int i = 0; i < n; i++) begin
            push_exp(d, r, f, rc, ll, tag);
            @(posedge CLKIN);
            #1;
            pop_check();
        end
    endtask

    initial begin
        rst         = 1'b0;
        locked      = 1'b0;
        force_reset = 1'b0;
        #1 rst = 1'b1;
        #1 check_now(1, 0, 0, 3'd0, 0, "reset_state");
        run(2, 1, 0, 0, 3'd0, 0, "reset_hold");

        // 1: normal bring-up, lock 5 cycles after release
        rst = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t1_pulse");
        run(2, 0, 0, 0, 3'd0, 0, "t1_wait");
        locked = 1'b1;
        run(10, 0, 0, 0, 3'd0, 0, "t1_settle");
        run(4, 0, 1, 0, 3'd0, 0, "t1_run");

        // 3: single-cycle lock drop in RUN
        locked = 1'b0;
        run(1, 0, 1, 0, 3'd0, 0, "t3_drop_sync");
        locked = 1'b1;
        run(1, 0, 1, 0, 3'd0, 0, "t3_drop_sync");
        run(4, 1, 0, 0, 3'd1, 1, "t3_pulse");
        run(9, 0, 0, 0, 3'd1, 1, "t3_relock");
        run(3, 0, 1, 0, 3'd1, 1, "t3_run");

        // 4: force restart, then a 1-cycle glitch at SETTLE cnt=5
        force_reset = 1'b1;
        run(1, 1, 0, 0, 3'd0, 0, "t4_force");
        force_reset = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t4_pulse");
        run(5, 0, 0, 0, 3'd0, 0, "t4_settle");
        locked = 1'b0;
        run(1, 0, 0, 0, 3'd0, 0, "t4_glitch");
        locked = 1'b1;
        run(1, 0, 0, 0, 3'd0, 0, "t4_glitch");
        run(4, 1, 0, 0, 3'd1, 0, "t4_retry_pulse");
        run(9, 0, 0, 0, 3'd1, 0, "t4_settle2");
        run(2, 0, 1, 0, 3'd1, 0, "t4_run");

        // 2: no lock -> three timeouts -> FAIL
        force_reset = 1'b1;
        locked      = 1'b0;
        run(1, 1, 0, 0, 3'd0, 0, "t2_force");
        force_reset = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t2_pulse0");
        run(20, 0, 0, 0, 3'd0, 0, "t2_wait0");
        run(4, 1, 0, 0, 3'd1, 0, "t2_pulse1");
        run(20, 0, 0, 0, 3'd1, 0, "t2_wait1");
        run(4, 1, 0, 0, 3'd2, 0, "t2_pulse2");
        run(20, 0, 0, 0, 3'd2, 0, "t2_wait2");
        run(1, 0, 0, 1, 3'd3, 0, "t2_fail");
        locked = 1'b1;
        run(8, 0, 0, 1, 3'd3, 0, "t2_fail_hold");

        // 5: force_reset out of FAIL, then force coincident with a timeout
        force_reset = 1'b1;
        run(1, 1, 0, 0, 3'd0, 0, "t5_force");
        force_reset = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t5_pulse");
        run(9, 0, 0, 0, 3'd0, 0, "t5_relock");
        run(2, 0, 1, 0, 3'd0, 0, "t5_run");
        force_reset = 1'b1;
        locked      = 1'b0;
        run(1, 1, 0, 0, 3'd0, 0, "t5_force2");
        force_reset = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t5_pulse2");
        run(20, 0, 0, 0, 3'd0, 0, "t5_wait");
        force_reset = 1'b1;
        run(3, 1, 0, 0, 3'd0, 0, "t5_force_timeout");
        force_reset = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t5_pulse3");
        run(2, 0, 0, 0, 3'd0, 0, "t5_wait3");

        // 6a: async reset mid-SETTLE
        locked = 1'b1;
        run(6, 0, 0, 0, 3'd0, 0, "t6_to_settle");
        rst = 1'b1;
        #1 check_now(1, 0, 0, 3'd0, 0, "t6_rst_settle");
        run(2, 1, 0, 0, 3'd0, 0, "t6_rst_hold");
        rst = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t6_pulse");
        run(9, 0, 0, 0, 3'd0, 0, "t6_relock");
        run(2, 0, 1, 0, 3'd0, 0, "t6_run");

        // 6b: build non-zero status, then async reset mid-RUN
        locked = 1'b0;
        run(1, 0, 1, 0, 3'd0, 0, "t6_drop_sync");
        locked = 1'b1;
        run(1, 0, 1, 0, 3'd0, 0, "t6_drop_sync");
        run(4, 1, 0, 0, 3'd1, 1, "t6_retry_pulse");
        run(9, 0, 0, 0, 3'd1, 1, "t6_relock2");
        run(2, 0, 1, 0, 3'd1, 1, "t6_run2");
        rst = 1'b1;
        #1 check_now(1, 0, 0, 3'd0, 0, "t6_rst_run");
        run(2, 1, 0, 0, 3'd0, 0, "t6_rst_hold2");
        rst = 1'b0;
        run(3, 1, 0, 0, 3'd0, 0, "t6_pulse2");
        run(9, 0, 0, 0, 3'd0, 0, "t6_relock3");
        run(2, 0, 1, 0, 3'd0, 0, "t6_run3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dll_rst_seq.md
Name: dll_rst_seq

Overview:
- Reset sequencer and lock supervisor for the clock-phase-adjust DLL.
- Drives the DLL `rst` input and watches its LOCKED output.
- Releases the DLL reset after a fixed pulse, waits for lock with a timeout, and qualifies lock for a settle interval before raising `ready`.
- Re-runs the reset on lock loss or timeout, up to a retry limit, then latches failure. Sits beside the DLL in the clock block; `ready` gates downstream logic that uses the shifted clock.

Parameters:
- RST_CYCLES, 4, number of CLKIN cycles `dll_rst` is held high per reset pulse (min 3).
- LOCK_TIMEOUT, 50000, CLKIN cycles allowed in WAIT_LOCK before a retry.
- SETTLE_CYCLES, 256, consecutive synchronized-locked cycles required before `ready`.
- MAX_RETRY, 7, failed attempts allowed before FAIL (1..7).
- CNT_W, 16, shared counter width; all cycle parameters must be below 2**CNT_W.

Ports:
- CLKIN  in  1  free-running reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  DLL LOCKED output; treated as asynchronous.
- force_reset  in  1  synchronous request to restart the sequence and clear status.
- dll_rst  out  1  registered reset to the DLL `rst` input.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  3  failed attempts since last `rst`/`force_reset`; saturates at MAX_RETRY.
- lock_lost  out  1  sticky; set when lock drops while in RUN.

Behaviour:
- `locked` passes through a 2-flop synchronizer to form `locked_s`. Latency is 2 cycles; both flops reset to 0.
- Async `rst` sets:
  - state=PULSE, cnt=0
  - dll_rst=1, ready=0, fail=0, retry_cnt=0, lock_lost=0
- All outputs are registered.
- PULSE:
  - dll_rst=1; cnt increments each cycle.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK and clear cnt. dll_rst goes 0 on that same edge.
  - So dll_rst stays high exactly RST_CYCLES cycles after rst release or after PULSE entry.
- WAIT_LOCK:
  - dll_rst=0; cnt increments.
  - If locked_s=1, go to SETTLE and clear cnt.
  - Else, if cnt==LOCK_TIMEOUT-1, take a retry event.
- SETTLE:
  - cnt increments while locked_s=1.
  - If locked_s=0, take a retry event.
  - If cnt==SETTLE_CYCLES-1 with locked_s=1, go to RUN; ready=1 from the next cycle.
- RUN:
  - ready=1.
  - If locked_s=0: set lock_lost=1, ready=0 next cycle, then take a retry event.
- Retry event:
  - If retry_cnt+1==MAX_RETRY: retry_cnt=MAX_RETRY, go to FAIL.
  - Else: retry_cnt increments, cnt=0, go to PULSE.
- FAIL:
  - dll_rst=0, fail=1, ready=0.
  - Holds until rst or force_reset. locked_s is ignored.
- force_reset=1 in any state:
  - Next state PULSE, cnt=0.
  - retry_cnt=0, fail=0, lock_lost=0, ready=0, dll_rst=1 next cycle.
  - It takes priority over any simultaneous retry event, timeout or RUN entry; retry_cnt is not incremented.
  - force_reset held high keeps the block in PULSE with cnt=0; PULSE length counts from deassertion.
- Boundary rules:
  - A locked_s glitch of 1 cycle in SETTLE counts as a retry.
  - locked_s already high on WAIT_LOCK entry goes to SETTLE the next cycle.
  - Unused state encodings recover to PULSE.
- Counter arithmetic is unsigned CNT_W wide; it never wraps because every compare exits first.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRY=3):
1. Release rst, assert locked 5 cycles after release, hold it -> dll_rst high for cycles 1-4. SETTLE entered 2 cycles after locked. ready=1 exactly 8 cycles of locked_s later. retry_cnt=0, fail=0.
2. locked stays low -> dll_rst repulses (4 cycles) every 24 cycles, retry_cnt 1 then 2. After the third timeout, fail=1 and retry_cnt=3; dll_rst stays 0 thereafter.
3. In RUN, drop locked for 1 cycle -> lock_lost=1 sticky, ready=0, 4-cycle dll_rst pulse, retry_cnt=1. Reassert locked -> ready returns; lock_lost stays 1.
4. In SETTLE at cnt=5, pulse locked low 1 cycle -> back to PULSE, retry_cnt increments, ready never rises.
5. In FAIL, pulse force_reset 1 cycle -> fail=0, retry_cnt=0, lock_lost=0, a 4-cycle dll_rst pulse, normal lock sequence. force_reset on the same cycle as a timeout -> retry_cnt stays 0.
6. Assert rst mid-SETTLE and mid-RUN -> all outputs return immediately (asynchronously) to reset values, dll_rst=1; the sequence restarts on release.
